eth_f_multi_ptr_sync_rx: RTL and testbench

- Receive-side pointer synchronizer for NUM_CH async FIFOs in the Ethernet packet-client MAC segment.
- Samples NUM_CH Gray-coded write pointers, launched from foreign-domain registers, through a SYNC_STAGES flop chain, then converts each to binary.
- Per channel, computes occupancy against a local binary read pointer and flags illegal pointer motion.
- Adds per-channel enable, warm-up qualification and sticky error reporting.

---
 rtl/eth_f_multi_ptr_sync_rx_if.sv | 36 +++
 rtl/eth_f_multi_ptr_sync_rx.sv | 174 +++++++++++++++++
 tb/tb_eth_f_multi_ptr_sync_rx.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_f_multi_ptr_sync_rx_if.sv
// ---------------------------------------------------------------------------
// eth_f_multi_ptr_sync_rx_if
// Bundle of the per-channel pointer-synchronizer signals.
//   gray_ptr_in : NUM_CH Gray write pointers from the foreign clock domain
//   local_ptr   : NUM_CH binary read pointers, local clock domain
//   ch_enable   : per-channel enable
//   err_clr     : per-channel one-cycle clear of err_jump
//   ptr_out     : synchronized binary pointers
//   occupancy   : ptr_out minus local_ptr, modulo 2^WIDTH
//   ptr_valid   : channel outputs are qualified
//   err_jump    : sticky illegal-motion flag
// Channel c occupies bits [c*WIDTH +: WIDTH] of every wide vector.
// ---------------------------------------------------------------------------
interface eth_f_multi_ptr_sync_rx_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
) ();
    logic [NUM_CH*WIDTH-1:0] gray_ptr_in;
    logic [NUM_CH*WIDTH-1:0] local_ptr;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       err_clr;
    logic [NUM_CH*WIDTH-1:0] ptr_out;
    logic [NUM_CH*WIDTH-1:0] occupancy;
    logic [NUM_CH-1:0]       ptr_valid;
    logic [NUM_CH-1:0]       err_jump;

    modport master (
        output gray_ptr_in, local_ptr, ch_enable, err_clr,
        input  ptr_out, occupancy, ptr_valid, err_jump
    );

    modport slave (
        input  gray_ptr_in, local_ptr, ch_enable, err_clr,
        output ptr_out, occupancy, ptr_valid, err_jump
    );
endinterface

// File: rtl/eth_f_multi_ptr_sync_rx.sv
// ---------------------------------------------------------------------------
// eth_f_multi_ptr_sync_rx
// Receive-side pointer synchronizer for NUM_CH async FIFOs. Each Gray write
// pointer is passed through a SYNC_STAGES flop chain, converted to binary,
// registered as ptr_out, and compared against the local read pointer to give
// occupancy. A per-channel IDLE/WARMUP/VALID FSM qualifies the outputs and a
// motion checker flags pointer advances larger than MAX_STEP (or backward).
// Ports:
//   clk   : single clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of eth_f_multi_ptr_sync_rx_if (see interface header)
// ---------------------------------------------------------------------------
module eth_f_multi_ptr_sync_rx #(
    parameter int WIDTH       = 8,
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 3,
    parameter int MAX_STEP    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    eth_f_multi_ptr_sync_rx_if.slave      bus
);

    localparam int              CNT_W      = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MAX_STEP_W = WIDTH'(MAX_STEP);
    localparam int              VEC_W      = NUM_CH * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_VALID  = 2'd2
    } state_e;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] gray);
        logic [WIDTH-1:0] bin;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    logic [VEC_W-1:0]  sync_r [SYNC_STAGES];
    logic [VEC_W-1:0]  ptr_out_s;
    logic [VEC_W-1:0]  occupancy_s;
    logic [NUM_CH-1:0] ptr_valid_s;
    logic [NUM_CH-1:0] err_jump_s;

    // Plain flop chain for all channels; no logic between stages, never gated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= {VEC_W{1'b0}};
            end
        end else begin
            sync_r[0] <= bus.gray_ptr_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] b_new_s;
        logic [WIDTH-1:0] delta_s;
        logic [WIDTH-1:0] occ_s;
        logic             viol_s;
        state_e           state_r;
        logic [CNT_W-1:0] cnt_r;
        logic [WIDTH-1:0] ptr_r;
        logic [WIDTH-1:0] occ_r;
        logic             valid_r;
        logic             err_r;

        // Decode the synchronized pointer and evaluate motion and occupancy.
        always_comb begin
            b_new_s = gray2bin(sync_r[SYNC_STAGES-1][c*WIDTH +: WIDTH]);
            delta_s = b_new_s - ptr_r;
            occ_s   = b_new_s - bus.local_ptr[c*WIDTH +: WIDTH];
            // Backward moves wrap to large deltas, so one compare covers both.
            if ((state_r == ST_VALID) && (delta_s > MAX_STEP_W)) begin
                viol_s = 1'b1;
            end else begin
                viol_s = 1'b0;
            end
        end

        // Channel FSM with registered pointer, occupancy, valid and error.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= ST_IDLE;
                cnt_r   <= {CNT_W{1'b0}};
                ptr_r   <= {WIDTH{1'b0}};
                occ_r   <= {WIDTH{1'b0}};
                valid_r <= 1'b0;
                err_r   <= 1'b0;
            end else begin
                ptr_r <= b_new_s;
                // A fresh violation takes priority over a clear in the same cycle.
                if (viol_s) begin
                    err_r <= 1'b1;
                end else if (bus.err_clr[c]) begin
                    err_r <= 1'b0;
                end else begin
                    err_r <= err_r;
                end
                // valid/occupancy follow the state being entered on this edge.
                case (state_r)
                    ST_IDLE: begin
                        valid_r <= 1'b0;
                        occ_r   <= {WIDTH{1'b0}};
                        if (bus.ch_enable[c]) begin
                            state_r <= ST_WARMUP;
                            cnt_r   <= CNT_LOAD;
                        end else begin
                            state_r <= ST_IDLE;
                            cnt_r   <= cnt_r;
                        end
                    end
                    ST_WARMUP: begin
                        if (!bus.ch_enable[c]) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= cnt_r;
                            valid_r <= 1'b0;
                            occ_r   <= {WIDTH{1'b0}};
                        end else if (cnt_r == CNT_LAST) begin
                            state_r <= ST_VALID;
                            cnt_r   <= cnt_r;
                            valid_r <= 1'b1;
                            occ_r   <= occ_s;
                        end else begin
                            state_r <= ST_WARMUP;
                            cnt_r   <= cnt_r - CNT_LAST;
                            valid_r <= 1'b0;
                            occ_r   <= {WIDTH{1'b0}};
                        end
                    end
                    ST_VALID: begin
                        cnt_r <= cnt_r;
                        if (!bus.ch_enable[c]) begin
                            state_r <= ST_IDLE;
                            valid_r <= 1'b0;
                            occ_r   <= {WIDTH{1'b0}};
                        end else begin
                            state_r <= ST_VALID;
                            valid_r <= 1'b1;
                            occ_r   <= occ_s;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                        valid_r <= 1'b0;
                        occ_r   <= {WIDTH{1'b0}};
                    end
                endcase
            end
        end

        assign ptr_out_s[c*WIDTH +: WIDTH]   = ptr_r;
        assign occupancy_s[c*WIDTH +: WIDTH] = occ_r;
        assign ptr_valid_s[c]                = valid_r;
        assign err_jump_s[c]                 = err_r;
    end

    assign bus.ptr_out   = ptr_out_s;
    assign bus.occupancy = occupancy_s;
    assign bus.ptr_valid = ptr_valid_s;
    assign bus.err_jump  = err_jump_s;

endmodule

// File: tb/tb_eth_f_multi_ptr_sync_rx.sv
// ---------------------------------------------------------------------------
// tb_eth_f_multi_ptr_sync_rx
// Table-driven bench for eth_f_multi_ptr_sync_rx (WIDTH=8, NUM_CH=4,
// SYNC_STAGES=3, MAX_STEP=1). Each row sets one channel's pointer inputs plus
// the enable/clear vectors, holds them for a number of clocks (err_clr only
// for the first of those clocks) and then compares against hand-derived
// expectations queued when the row was driven. A row may request an
// asynchronous reset pulse between edges before it is applied.
// ---------------------------------------------------------------------------
module tb_eth_f_multi_ptr_sync_rx;

    localparam int W  = 8;
    localparam int NC = 4;

    typedef struct {
        bit         pulse_rst;
        int         ch;
        int         g;
        int         lp;
        logic [3:0] en;
        logic [3:0] clr;
        int         hold;
        int         e_ptr;
        int         e_occ;
        logic [3:0] e_valid;
        logic [3:0] e_err;
    } row_t;

    typedef struct {
        int         row;
        int         ch;
        logic [7:0] ptr;
        logic [7:0] occ;
        logic [3:0] valid;
        logic [3:0] err;
    } exp_t;

    logic clk;
    logic rst_n;
    row_t rows[$];
    exp_t sb[$];
    int   cur_g  [NC];
    int   cur_lp [NC];
    int   n_checks;
    int   n_errors;

    eth_f_multi_ptr_sync_rx_if #(.WIDTH(W), .NUM_CH(NC)) bus ();

    eth_f_multi_ptr_sync_rx #(
        .WIDTH(W), .NUM_CH(NC), .SYNC_STAGES(3), .MAX_STEP(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1);
    end

    function automatic logic [7:0] to_gray(input int v);
        logic [7:0] b;
        b = 8'(v);
        return b ^ (b >> 1);
    endfunction

    function automatic void add(input bit rp, input int ch, input int g, input int lp,
                                input logic [3:0] en, input logic [3:0] clr, input int hold,
                                input int e_ptr, input int e_occ,
                                input logic [3:0] e_valid, input logic [3:0] e_err);
        row_t r;
        r.pulse_rst = rp; r.ch = ch; r.g = g; r.lp = lp; r.en = en; r.clr = clr;
        r.hold = hold; r.e_ptr = e_ptr; r.e_occ = e_occ;
        r.e_valid = e_valid; r.e_err = e_err;
        rows.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_ptrs();
        for (int c = 0; c < NC; c++) begin
            bus.gray_ptr_in[c*W +: W] = to_gray(cur_g[c]);
            bus.local_ptr[c*W +: W]   = 8'(cur_lp[c]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " ptr_out"},   32'(bus.ptr_out),   32'd0);
        chk({tag, " occupancy"}, 32'(bus.occupancy), 32'd0);
        chk({tag, " ptr_valid"}, 32'(bus.ptr_valid), 32'd0);
        chk({tag, " err_jump"},  32'(bus.err_jump),  32'd0);
    endtask

    initial begin
        exp_t e;
        n_checks = 0;
        n_errors = 0;

        // ---- vector table (expectations follow 4-edge pointer latency) ----
        // latency and warm-up on ch0: gray(5) held from reset
        add(0, 0,   5,   0, 4'b1111, 4'b0000, 3,   0,  0, 4'b0000, 4'b0000);
        add(0, 0,   5,   0, 4'b1111, 4'b0000, 1,   5,  0, 4'b0000, 4'b0000);
        add(0, 0,   5,   0, 4'b1111, 4'b0000, 1,   5,  5, 4'b1111, 4'b0000);
        // park ch0, move it to 250, re-enable: valid 5 edges later
        add(0, 0, 250, 250, 4'b1110, 4'b0000, 1,   5,  0, 4'b1110, 4'b0000);
        add(0, 0, 250, 250, 4'b1111, 4'b0000, 3, 250,  0, 4'b1110, 4'b0000);
        add(0, 0, 250, 250, 4'b1111, 4'b0000, 1, 250,  0, 4'b1110, 4'b0000);
        add(0, 0, 250, 250, 4'b1111, 4'b0000, 1, 250,  0, 4'b1111, 4'b0000);
        // single-step ramp through the 255 -> 0 wrap
        add(0, 0, 251, 250, 4'b1111, 4'b0000, 1, 250,  0, 4'b1111, 4'b0000);
        add(0, 0, 252, 250, 4'b1111, 4'b0000, 1, 250,  0, 4'b1111, 4'b0000);
        add(0, 0, 253, 250, 4'b1111, 4'b0000, 1, 250,  0, 4'b1111, 4'b0000);
        add(0, 0, 254, 250, 4'b1111, 4'b0000, 1, 251,  1, 4'b1111, 4'b0000);
        add(0, 0, 255, 250, 4'b1111, 4'b0000, 1, 252,  2, 4'b1111, 4'b0000);
        add(0, 0,   0, 250, 4'b1111, 4'b0000, 1, 253,  3, 4'b1111, 4'b0000);
        add(0, 0,   1, 250, 4'b1111, 4'b0000, 1, 254,  4, 4'b1111, 4'b0000);
        add(0, 0,   2, 250, 4'b1111, 4'b0000, 1, 255,  5, 4'b1111, 4'b0000);
        add(0, 0,   3, 250, 4'b1111, 4'b0000, 1,   0,  6, 4'b1111, 4'b0000);
        add(0, 0,   3, 250, 4'b1111, 4'b0000, 3,   3,  9, 4'b1111, 4'b0000);
        // legal ramp up to 10 with local pointer 0
        add(0, 0,   4,   0, 4'b1111, 4'b0000, 1,   3,  3, 4'b1111, 4'b0000);
        add(0, 0,   5,   0, 4'b1111, 4'b0000, 1,   3,  3, 4'b1111, 4'b0000);
        add(0, 0,   6,   0, 4'b1111, 4'b0000, 1,   3,  3, 4'b1111, 4'b0000);
        add(0, 0,   7,   0, 4'b1111, 4'b0000, 1,   4,  4, 4'b1111, 4'b0000);
        add(0, 0,   8,   0, 4'b1111, 4'b0000, 1,   5,  5, 4'b1111, 4'b0000);
        add(0, 0,   9,   0, 4'b1111, 4'b0000, 1,   6,  6, 4'b1111, 4'b0000);
        add(0, 0,  10,   0, 4'b1111, 4'b0000, 4,  10, 10, 4'b1111, 4'b0000);
        // forward jump 10 -> 13: flag appears with the new pointer, sticky
        add(0, 0,  13,   0, 4'b1111, 4'b0000, 3,  10, 10, 4'b1111, 4'b0000);
        add(0, 0,  13,   0, 4'b1111, 4'b0000, 1,  13, 13, 4'b1111, 4'b0001);
        add(0, 0,  13,   0, 4'b1111, 4'b0000, 2,  13, 13, 4'b1111, 4'b0001);
        add(0, 0,  13,   0, 4'b1111, 4'b0001, 1,  13, 13, 4'b1111, 4'b0000);
        // backward move 13 -> 12
        add(0, 0,  12,   0, 4'b1111, 4'b0000, 4,  12, 12, 4'b1111, 4'b0001);
        // clear coinciding with a new violation (12 -> 20): set wins
        add(0, 0,  20,   0, 4'b1111, 4'b0000, 3,  12, 12, 4'b1111, 4'b0001);
        add(0, 0,  20,   0, 4'b1111, 4'b0001, 1,  20, 20, 4'b1111, 4'b0001);
        add(0, 0,  20,   0, 4'b1111, 4'b0000, 1,  20, 20, 4'b1111, 4'b0001);
        add(0, 0,  20,   0, 4'b1111, 4'b0001, 1,  20, 20, 4'b1111, 4'b0000);
        // ch2 disable in VALID: pointer keeps tracking, occupancy forced 0
        add(0, 2,  40,   0, 4'b1011, 4'b0000, 1,  40,  0, 4'b1011, 4'b0000);
        add(0, 2,  41,   0, 4'b1011, 4'b0000, 4,  41,  0, 4'b1011, 4'b0000);
        add(0, 2,  41,   0, 4'b1111, 4'b0000, 4,  41,  0, 4'b1011, 4'b0000);
        add(0, 2,  41,   0, 4'b1111, 4'b0000, 1,  41, 41, 4'b1111, 4'b0000);
        add(0, 3,  60,  10, 4'b1111, 4'b0000, 1,  60, 50, 4'b1111, 4'b0000);
        // set an error on ch0 (20 -> 30), then reset mid-operation
        add(0, 0,  30,   0, 4'b1111, 4'b0000, 4,  30, 30, 4'b1111, 4'b0001);
        add(1, 0,  30,   0, 4'b1111, 4'b0000, 4,  30,  0, 4'b0000, 4'b0000);
        add(0, 0,  30,   0, 4'b1111, 4'b0000, 1,  30, 30, 4'b1111, 4'b0000);

        // ---- reset state ----
        cur_g  = '{5, 20, 40, 60};
        cur_lp = '{0, 0, 0, 0};
        rst_n = 1'b0;
        bus.ch_enable = 4'b0000;
        bus.err_clr   = 4'b0000;
        drive_ptrs();
        #22;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ---- apply table ----
        foreach (rows[i]) begin
            if (rows[i].pulse_rst) begin
                #2 rst_n = 1'b0;
                #1;
                check_all_zero("async_reset");
                rst_n = 1'b1;
            end
            cur_g[rows[i].ch]  = rows[i].g;
            cur_lp[rows[i].ch] = rows[i].lp;
            drive_ptrs();
            bus.ch_enable = rows[i].en;
            bus.err_clr   = rows[i].clr;
            e.row   = i;
            e.ch    = rows[i].ch;
            e.ptr   = 8'(rows[i].e_ptr);
            e.occ   = 8'(rows[i].e_occ);
            e.valid = rows[i].e_valid;
            e.err   = rows[i].e_err;
            sb.push_back(e);
            for (int k = 0; k < rows[i].hold; k++) begin
                @(posedge clk);
                @(negedge clk);
                bus.err_clr = 4'b0000;
            end
            e = sb.pop_front();
            chk($sformatf("row%0d ch%0d ptr_out", e.row, e.ch),
                32'(bus.ptr_out[e.ch*W +: W]), 32'(e.ptr));
            chk($sformatf("row%0d ch%0d occupancy", e.row, e.ch),
                32'(bus.occupancy[e.ch*W +: W]), 32'(e.occ));
            chk($sformatf("row%0d ptr_valid", e.row), 32'(bus.ptr_valid), 32'(e.valid));
            chk($sformatf("row%0d err_jump", e.row), 32'(bus.err_jump), 32'(e.err));
        end

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
